shift_sum_accum: RTL and testbench

- Parametrised successor to the fixed 3-input shift-weighted sum with running accumulation.
- Each accepted beat carries CHANNELS operands. The block forms a shift-weighted sum of the beat, then folds DEPTH beats into a frame result using add or XOR.
- It presents the frame result on a valid/ready output. It sits between a sample source and a downstream consumer in the same clock domain.

---
 rtl/shift_sum_accum.sv | 134 +++++++++++++
 tb/tb_shift_sum_accum.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sum_accum.sv
// Shift-weighted multi-channel sample sum, folded over DEPTH beats into one frame result (add or XOR).
// Latency: sample_sum 1 cycle after accept; frame result valid on the edge accepting the final beat.
// Backpressure: in_ready is low while a result waits in HOLD; it returns the cycle after the out handshake.
module shift_sum_accum #(
  parameter int WIDTH      = 8,
  parameter int IN_WIDTH   = 4,
  parameter int CHANNELS   = 3,
  parameter int SHIFT_STEP = 2,
  parameter int DEPTH      = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          acc_op,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  output logic [WIDTH-1:0]              sample_sum,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              acc_out,
  output logic [$clog2(DEPTH+1)-1:0]    beat_cnt
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               op_q;
  logic               op_nxt;
  logic [WIDTH-1:0]   w;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   sum_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;
  logic               unused_in_bits;

  // Only the low IN_WIDTH bits of each channel are operands; the rest are intentionally ignored.
  assign unused_in_bits = ^in_data;

  // Handshake flags come straight from the state register, so there is no path from in_valid.
  assign in_ready = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept = in_valid && in_ready && !clr;
  assign cnt_inc = beat_cnt + CNT_W'(1);

  // Weighted sum kept at WIDTH bits: addition and shifts wrap mod 2^WIDTH, which is the same as
  // computing full width and truncating. Bits shifted past WIDTH fall off.
  always_comb begin
    logic [WIDTH-1:0] opnd;
    w = '0;
    opnd = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      opnd = '0;
      opnd[IN_WIDTH-1:0] = in_data[k*WIDTH +: IN_WIDTH];
      w = w + (opnd << (k * SHIFT_STEP));
    end
  end

  // Next-state and datapath updates; clr overrides everything except reset.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_out;
    sum_nxt   = sample_sum;
    cnt_nxt   = beat_cnt;
    op_nxt    = op_q;

    if (clr) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      if (accept) begin
        sum_nxt = w;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            // Accumulator starts from zero; 0+w and 0^w are both w.
            op_nxt    = acc_op;
            acc_nxt   = w;
            cnt_nxt   = CNT_W'(1);
            state_nxt = (DEPTH == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            // Operation was latched on the frame's first beat; acc_op is ignored here.
            acc_nxt = op_q ? (acc_out ^ w) : (acc_out + w);
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_W'(DEPTH)) begin
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          // Result stays put until taken; acc_out keeps its value after the handshake.
          if (out_ready) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc_out    <= '0;
      sample_sum <= '0;
      beat_cnt   <= '0;
      op_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc_out    <= acc_nxt;
      sample_sum <= sum_nxt;
      beat_cnt   <= cnt_nxt;
      op_q       <= op_nxt;
    end
  end

endmodule

// File: tb/tb_shift_sum_accum.sv
// Bench for shift_sum_accum: default configuration plus a CHANNELS=5/SHIFT_STEP=1/DEPTH=1 instance.
// Inputs change away from the rising edge; outputs are sampled on the falling edge.
// Frame results are queued when the last beat is driven and popped when out_valid shows.
module tb_shift_sum_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst_n, clr, acc_op, in_valid, in_ready, out_valid, out_ready;
  logic [23:0] in_data;
  logic [7:0]  sample_sum, acc_out;
  logic [1:0]  beat_cnt;

  // CHANNELS=5, SHIFT_STEP=1, DEPTH=1 instance
  logic        d2_clr, d2_acc_op, d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic [39:0] d2_in_data;
  logic [7:0]  d2_sample_sum, d2_acc_out;
  logic [0:0]  d2_beat_cnt;

  shift_sum_accum dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .acc_op(acc_op),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sample_sum(sample_sum), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .beat_cnt(beat_cnt)
  );

  shift_sum_accum #(.CHANNELS(5), .SHIFT_STEP(1), .DEPTH(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(d2_clr), .acc_op(d2_acc_op),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data),
    .sample_sum(d2_sample_sum), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .acc_out(d2_acc_out), .beat_cnt(d2_beat_cnt)
  );

  int total = 0;
  int bad   = 0;
  int m_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] q2[$];

  typedef struct {
    logic [23:0] data;
    logic        op;
    logic [7:0]  exp_sum;
    logic [7:0]  exp_acc;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference weighted sum using multiplication by powers of two and integer modulo.
  function automatic logic [7:0] model_w(input logic [39:0] d, input int ch, input int step);
    int s;
    s = 0;
    for (int k = 0; k < ch; k++) begin
      s += int'((d >> (8 * k)) & 40'hF) * (1 << (k * step));
    end
    return 8'(s % 256);
  endfunction

  // One beat into the default instance; expects the frame's running result exp_acc.
  task automatic send_beat(input logic [23:0] data, input logic op,
                           input logic [7:0] w, input logic [7:0] exp_acc);
    @(negedge clk);
    check("in_ready_before_beat", in_ready, 1);
    in_valid = 1'b1;
    in_data  = data;
    acc_op   = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_cnt++;
    if (m_cnt == 3) begin
      exp_q.push_back(exp_acc);
      m_cnt = 0;
    end
    @(negedge clk);
    check("sample_sum", sample_sum, w);
    check("beat_cnt", beat_cnt, (m_cnt == 0) ? 3 : m_cnt);
    check("acc_running", acc_out, exp_acc);
    check("out_valid_after_beat", out_valid, (m_cnt == 0) ? 1 : 0);
  endtask

  // Pop the expected frame result, hold out_ready low for `stall` cycles with in_valid high,
  // then handshake and confirm there is no same-cycle restart.
  task automatic take_result(input int stall);
    logic [7:0] exp;
    logic [7:0] held_sum;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got out_valid=%0d expected a queued result", out_valid);
      return;
    end
    exp = exp_q.pop_front();
    held_sum = sample_sum;
    check("frame_valid", out_valid, 1);
    check("frame_result", acc_out, exp);
    in_valid = 1'b1;
    in_data  = 24'hABCDEF;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
      check("hold_acc", acc_out, exp);
      check("hold_cnt", beat_cnt, 3);
      check("hold_sample", sample_sum, held_sum);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_cnt", beat_cnt, 0);
    check("post_hs_acc_kept", acc_out, exp);
    check("post_hs_sample", sample_sum, held_sum);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] d2d;
    logic [7:0]  w2;

    // frames: add 0x56, xor 0x72, xor with mid-frame op toggles 0x72, add wrap 0xAF, xor 0x02
    vecs[0]  = '{24'h563412, 1'b0, 8'h72, 8'h72};
    vecs[1]  = '{24'h563412, 1'b0, 8'h72, 8'hE4};
    vecs[2]  = '{24'h563412, 1'b0, 8'h72, 8'h56};
    vecs[3]  = '{24'h563412, 1'b1, 8'h72, 8'h72};
    vecs[4]  = '{24'h563412, 1'b1, 8'h72, 8'h00};
    vecs[5]  = '{24'h563412, 1'b1, 8'h72, 8'h72};
    vecs[6]  = '{24'h563412, 1'b1, 8'h72, 8'h72};
    vecs[7]  = '{24'h563412, 1'b0, 8'h72, 8'h00};
    vecs[8]  = '{24'h563412, 1'b0, 8'h72, 8'h72};
    vecs[9]  = '{24'hFFFFFF, 1'b0, 8'h3B, 8'h3B};
    vecs[10] = '{24'h030201, 1'b0, 8'h39, 8'h74};
    vecs[11] = '{24'h0F0F0F, 1'b0, 8'h3B, 8'hAF};
    vecs[12] = '{24'hFFFFFF, 1'b1, 8'h3B, 8'h3B};
    vecs[13] = '{24'h030201, 1'b1, 8'h39, 8'h02};
    vecs[14] = '{24'hF0F0F0, 1'b1, 8'h00, 8'h02};

    rst_n = 1'b1; clr = 1'b0; acc_op = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    d2_clr = 1'b0; d2_acc_op = 1'b0; d2_in_valid = 1'b0; d2_out_ready = 1'b0; d2_in_data = '0;
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_acc", acc_out, 0);
    check("rst_sample", sample_sum, 0);
    check("rst_cnt", beat_cnt, 0);
    check("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Table-driven frames; first frame is backpressured for 5 cycles.
    for (int i = 0; i < 15; i++) begin
      send_beat(vecs[i].data, vecs[i].op, vecs[i].exp_sum, vecs[i].exp_acc);
      if (i % 3 == 2) take_result((i == 2) ? 5 : 0);
    end

    // clr after two beats with a beat offered in the same cycle.
    send_beat(24'h010101, 1'b0, 8'h15, 8'h15);
    send_beat(24'h020202, 1'b0, 8'h2A, 8'h3F);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_data = 24'h0F0F0F;
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    check("clr_cnt", beat_cnt, 0);
    check("clr_acc", acc_out, 0);
    check("clr_out_valid", out_valid, 0);
    check("clr_sample_kept", sample_sum, 8'h2A);
    check("clr_in_ready", in_ready, 1);
    send_beat(24'h010101, 1'b0, 8'h15, 8'h15);
    send_beat(24'h010101, 1'b0, 8'h15, 8'h2A);
    send_beat(24'h010101, 1'b0, 8'h15, 8'h3F);
    take_result(0);

    // clr while a result is held discards it.
    send_beat(24'h111111, 1'b1, 8'h15, 8'h15);
    send_beat(24'h111111, 1'b1, 8'h15, 8'h00);
    send_beat(24'h111111, 1'b1, 8'h15, 8'h15);
    void'(exp_q.pop_front());
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_hold_valid", out_valid, 0);
    check("clr_hold_acc", acc_out, 0);
    check("clr_hold_in_ready", in_ready, 1);

    // Asynchronous reset between edges while holding a result.
    send_beat(24'h030201, 1'b0, 8'h39, 8'h39);
    send_beat(24'h030201, 1'b0, 8'h39, 8'h72);
    send_beat(24'h030201, 1'b0, 8'h39, 8'hAB);
    void'(exp_q.pop_front());
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_acc", acc_out, 0);
    check("arst_cnt", beat_cnt, 0);
    check("arst_sample", sample_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-beat frames on the wider instance.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("d2_in_ready", d2_in_ready, 1);
      d2d = (i == 0) ? 40'hFFFFFFFFFF : {$urandom_range(255, 0), $urandom, $urandom_range(0, 0)} >> 8;
      w2  = (i == 0) ? 8'hD1 : model_w(d2d, 5, 1);
      d2_in_valid = 1'b1;
      d2_in_data  = d2d;
      d2_acc_op   = i[0];
      @(posedge clk);
      #1;
      d2_in_valid = 1'b0;
      q2.push_back(w2);
      @(negedge clk);
      check("d2_out_valid", d2_out_valid, 1);
      if (q2.size() != 0) check("d2_acc", d2_acc_out, q2.pop_front());
      check("d2_sample", d2_sample_sum, w2);
      check("d2_cnt", d2_beat_cnt, 1);
      check("d2_in_ready_hold", d2_in_ready, 0);
      d2_out_ready = 1'b1;
      @(posedge clk);
      #1;
      d2_out_ready = 1'b0;
      @(negedge clk);
      check("d2_post_hs_valid", d2_out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
